// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter: FSM state
// encoding, BCD digit geometry, the add-3 correction constants, and the
// elaboration-time digit-count check.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DIGIT_W = 4;

  // A digit at or above this value would exceed 9 after the next doubling,
  // so it gets ADJ_OFFSET added before the shift.
  localparam logic [DIGIT_W-1:0] ADJ_THRESHOLD = 4'd5;
  localparam logic [DIGIT_W-1:0] ADJ_OFFSET    = 4'd3;

  // True when ndig decimal digits can hold the largest nbits-wide operand,
  // i.e. 10^ndig > 2^nbits - 1.
  function automatic bit ndig_fits(input int nbits, input int ndig);
    longint unsigned p10;
    longint unsigned maxv;
    p10  = 64'd1;
    maxv = (64'd1 << nbits) - 64'd1;
    for (int i = 0; i < ndig; i++) begin
      p10 = p10 * 64'd10;
    end
    return (p10 > maxv);
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Single-digit add-3 correction cell for double-dabble: a digit of 5 or more
// gets 3 added so that the following left shift carries correctly into the
// next decimal digit. Purely combinational.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  // Conditional add-3; inputs are always 0-9 so the sum never wraps.
  always_comb begin
    dout = din;
    if (din >= ADJ_THRESHOLD) begin
      dout = din + ADJ_OFFSET;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Accepts an operand through start/ready, shifts NBITS times, then presents
// the packed BCD result with a one-cycle done pulse. The result register holds
// its value between conversions.
// Optional feature: define BIN2BCD_BLANKING_EN to add the registered
// leading-zero mask output `blank`.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int NBITS = 8,
  parameter int NDIG  = 3
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start,
  input  logic [NBITS-1:0]        bin,
  output logic                    ready,
  output logic                    done,
  output logic [DIGIT_W*NDIG-1:0] bcd
`ifdef BIN2BCD_BLANKING_EN
  ,
  output logic [NDIG-1:0]         blank
`endif
);

  localparam int BCD_W = DIGIT_W * NDIG;
  localparam int CNT_W = $clog2(NBITS + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NBITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  // Reject digit counts that cannot represent the all-ones operand.
  if (!ndig_fits(NBITS, NDIG)) begin : g_ndig_check
    $fatal(1, "bin2bcd_seq: NDIG=%0d cannot hold 2^%0d-1", NDIG, NBITS);
  end

  state_t           state;
  logic [NBITS-1:0] bin_work;
  logic [BCD_W-1:0] bcd_work;
  logic [CNT_W-1:0] cnt;
  logic [BCD_W-1:0] bcd_adj;
  logic [BCD_W-1:0] bcd_next;

  // One correction cell per digit of the working BCD register.
  for (genvar g = 0; g < NDIG; g++) begin : g_digit
    bcd_digit_adj u_adj (
      .din  (bcd_work[g*DIGIT_W +: DIGIT_W]),
      .dout (bcd_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // Corrected digits shifted left by one with the binary MSB entering bit 0.
  // The dropped top bit is always zero because NDIG covers the full range.
  assign bcd_next = BCD_W'({bcd_adj, bin_work[NBITS-1]});

`ifdef BIN2BCD_BLANKING_EN
  localparam logic [NDIG-1:0] BLANK_RST = ~NDIG'(1);

  logic [NDIG-1:0] blank_next;
  logic            higher_zero;

  // Leading-zero mask of the result being loaded; digit 0 is never blanked.
  always_comb begin
    blank_next  = '0;
    higher_zero = 1'b1;
    for (int i = NDIG - 1; i >= 1; i--) begin
      higher_zero   = higher_zero && (bcd_next[i*DIGIT_W +: DIGIT_W] == '0);
      blank_next[i] = higher_zero;
    end
  end
`endif

  // Control FSM with counter, working registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      ready    <= 1'b1;
      done     <= 1'b0;
      bcd      <= '0;
      bin_work <= '0;
      bcd_work <= '0;
      cnt      <= '0;
`ifdef BIN2BCD_BLANKING_EN
      blank    <= BLANK_RST;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_work <= bin;
            bcd_work <= '0;
            cnt      <= CNT_LOAD;
            ready    <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_work <= bcd_next;
          bin_work <= bin_work << 1;
          cnt      <= cnt - 1'b1;
          if (cnt == CNT_LAST) begin
            bcd   <= bcd_next;
            done  <= 1'b1;
            state <= DONE;
`ifdef BIN2BCD_BLANKING_EN
            blank <= blank_next;
`endif
          end
        end
        DONE: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
